// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, iterative shift-add multiply
// and bit-serial shifts, with valid/ready handshakes on both sides.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             busy
);

   // Handshake: an operation transfers in on a rising edge where in_valid && in_ready,
   // and a result transfers out on a rising edge where out_valid && out_ready; neither
   // ready depends combinationally on the other side's valid.

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [SW:0] CNT_ONE = {{SW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [SW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             flag_c_q, flag_c_d;
   logic             flag_z_q, flag_z_d;
   logic             flag_n_q, flag_n_d;
   logic             flag_v_q, flag_v_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_next;
   logic [WIDTH-1:0] mul_lo_next;
   logic [WIDTH-1:0] sh_next;
   logic             sh_out;

   assign add_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   // hi:lo is the running product; lo starts as the multiplier and is consumed LSB first.
   assign mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign mul_hi_next = mul_sum[WIDTH:1];
   assign mul_lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};

   assign sh_out  = (op_q == OP_SHL) ? lo_q[WIDTH-1] : lo_q[0];
   assign sh_next = (op_q == OP_SHL) ? {lo_q[WIDTH-2:0], 1'b0} : {1'b0, lo_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      mcand_d     = mcand_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flag_c_d    = flag_c_q;
      flag_z_d    = flag_z_q;
      flag_n_d    = flag_n_q;
      flag_v_d    = flag_v_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = opcode;
               mcand_d = a;
               hi_d    = '0;
               lo_d    = a;
               state_d = S_DONE;
               case (opcode)
                  OP_ADD: begin
                     result_d = add_sum[WIDTH-1:0];
                     flag_c_d = add_sum[WIDTH];
                     flag_v_d = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_SUB: begin
                     result_d = sub_sum[WIDTH-1:0];
                     flag_c_d = sub_sum[WIDTH];
                     flag_v_d = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_AND, OP_OR, OP_XOR: begin
                     result_d = (opcode == OP_AND) ? (a & b) :
                                (opcode == OP_OR)  ? (a | b) : (a ^ b);
                     flag_c_d = 1'b0;
                     flag_v_d = 1'b0;
                  end
                  OP_MUL: begin
                     lo_d    = b;
                     cnt_d   = (SW+1)'(WIDTH);
                     state_d = S_BUSY;
                  end
                  default: begin
                     if (b[SW-1:0] == '0) begin
                        result_d = a;
                        flag_c_d = 1'b0;
                        flag_v_d = 1'b0;
                     end else begin
                        cnt_d   = {1'b0, b[SW-1:0]};
                        state_d = S_BUSY;
                     end
                  end
               endcase
               if (state_d == S_DONE) begin
                  result_hi_d = '0;
                  flag_z_d    = (result_d == '0);
                  flag_n_d    = result_d[WIDTH-1];
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (op_q == OP_MUL) begin
               hi_d = mul_hi_next;
               lo_d = mul_lo_next;
            end else begin
               lo_d = sh_next;
            end
            // Outputs are only touched on the final step so partial values never show.
            if (cnt_q == CNT_ONE) begin
               state_d  = S_DONE;
               flag_v_d = 1'b0;
               if (op_q == OP_MUL) begin
                  result_d    = mul_lo_next;
                  result_hi_d = mul_hi_next;
                  flag_c_d    = |mul_hi_next;
                  flag_z_d    = ({mul_hi_next, mul_lo_next} == '0);
                  flag_n_d    = mul_lo_next[WIDTH-1];
               end else begin
                  result_d    = sh_next;
                  result_hi_d = '0;
                  flag_c_d    = sh_out;
                  flag_z_d    = (sh_next == '0);
                  flag_n_d    = sh_next[WIDTH-1];
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ADD;
         mcand_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         flag_c_q    <= 1'b0;
         flag_z_q    <= 1'b0;
         flag_n_q    <= 1'b0;
         flag_v_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         mcand_q     <= mcand_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         flag_c_q    <= flag_c_d;
         flag_z_q    <= flag_z_d;
         flag_n_q    <= flag_n_d;
         flag_v_q    <= flag_v_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign flag_c    = flag_c_q;
   assign flag_z    = flag_z_q;
   assign flag_n    = flag_n_q;
   assign flag_v    = flag_v_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit ripple ALU.
- Adds new operations to ADD/SUB/AND/OR: XOR, an iterative shift-add multiply and iterative shifts.
- Adds status flags and valid/ready handshakes on both input and output.
- Sits between an operand issue stage and a result writeback stage; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values 2..32.
- SW, $clog2(WIDTH), shift-amount width; derived, must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an operation
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 SHR
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; for shifts only b[SW-1:0] is used as the amount
- cin  in  1  carry-in; used by ADD only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result, low half for MUL
- result_hi  out  WIDTH  high half of MUL product; 0 for all other ops
- flag_c  out  1  carry / not-borrow / shifted-out bit / MUL high-half nonzero
- flag_z  out  1  result zero (MUL: full 2*WIDTH product zero)
- flag_n  out  1  result[WIDTH-1]
- flag_v  out  1  signed overflow; ADD/SUB only, else 0
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; result, result_hi, all flags=0; busy=0. Any in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating MUL or shift.
  - DONE: out_valid=1.
  - in_ready is low in BUSY and DONE.
- Accept at edge E when in_valid && in_ready. a, b, opcode and cin are captured at E; later input changes have no effect.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, and SHL/SHR with amount 0): result and flags are registered at E; state goes to DONE at E; out_valid is visible in the cycle after E.
- ADD: {flag_c,result} = a+b+cin, computed at WIDTH+1 bits.
- SUB: {flag_c,result} = a+~b+1; cin is ignored; flag_c=1 means no borrow.
- flag_v (ADD/SUB): operand sign bits agree (b inverted for SUB) and the result sign differs.
- AND/OR/XOR: flag_c=0, flag_v=0.
- MUL: unsigned shift-add, one partial product per cycle. State goes to BUSY at E and to DONE at edge E+WIDTH. result/result_hi form the 2*WIDTH product; flag_c = |result_hi; flag_n = result[WIDTH-1].
- SHL/SHR (logical, zero fill): one bit per cycle. For amount k>0, BUSY for k cycles, DONE at edge E+k. flag_c = last bit shifted out. k >= WIDTH is legal and yields 0.
- Intermediate values are not visible: result and flags change only on entry to DONE.
- DONE holds result, flags and out_valid stable until out_valid && out_ready at some edge; the block returns to IDLE at that edge (out_valid low, in_ready high next cycle).
- in_valid is ignored outside IDLE.
- Maximum throughput is one operation per 2 cycles.
- out_ready is ignored outside DONE.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 cin=0 -> result=0x80, c=0, z=0, n=1, v=1; out_valid high in the cycle after acceptance.
- SUB a=0x05 b=0x07 -> result=0xFE, c=0 (borrow), n=1, v=0; then SUB 0x07-0x07 -> result=0x00, z=1, c=1.
- MUL a=0xFF b=0xFF -> result=0x01, result_hi=0xFE, c=1, z=0; out_valid rises after edge E+8; in_ready stays low and a second in_valid is ignored throughout.
- SHL a=0x81 b=1 -> result=0x02, c=1 after 1 BUSY cycle; SHR a=0x81 b=0 -> result=0x81, c=0, single-cycle; SHR a=0xFF b=3 -> 0x1F, c=1.
- Backpressure: ADD 0x10+0x20, hold out_ready low 5 cycles -> result=0x30 and flags stable, out_valid high throughout; transfer on the first out_ready cycle; in_ready high the next cycle.
- Reset: assert rst_n low 3 cycles into a MUL -> all outputs 0 and in_ready=1 immediately; after release, ADD 0x01+0x01 -> result=0x02 with no stale MUL result emitted.
